pipeline_issue_ctrl: RTL and testbench
======================================

// Module: pipeline_issue_ctrl
// PURPOSE
//   Issue scheduler for the 3-stage complex-ALU pipeline (fetch -> memory read -> ALU/writeback).
//   Accepts instructions {op, waddr, raddr1, raddr2} from the fetch side over a valid/ready handshake.
//   Detects read-after-write hazards against in-flight destinations and inserts bubbles until the
//   producing result is written back. Drives the pipeline issue registers.
//   Keeps issue and stall statistics.
// PARAMETERS
//   HAZ_WIN   3    cycles a destination stays busy after issue (range 1..8)
//   AW        5    register-file address width
//   CNT_W     16   width of the issue/stall counters
// PORTS
//   clk         in   1     clock, all state updates on rising edge
//   rst         in   1     asynchronous reset, active high
//   en          in   1     issue enable; 0 = hold off issue, emit bubbles
//   flush       in   1     synchronous flush of issue register and scoreboard
//   in_valid    in   1     instruction present on in_* fields
//   in_ready    out  1     instruction accepted this edge when in_valid & in_ready
//   in_op       in   2     ALU op
//   in_waddr    in   AW    destination address
//   in_raddr1   in   AW    source address 1
//   in_raddr2   in   AW    source address 2
//   iss_valid   out  1     issued instruction valid; 0 = bubble
//   iss_op      out  2     issued op
//   iss_waddr   out  AW    issued destination
//   iss_raddr1  out  AW    issued source 1
//   iss_raddr2  out  AW    issued source 2
//   busy        out  1     any scoreboard entry valid
//   issue_cnt   out  CNT_W accepted-instruction count, saturating
//   stall_cnt   out  CNT_W hazard-stall cycle count, saturating
// BEHAVIOUR
// - Reset (async, rst=1): iss_valid=0; iss_op/iss_* = 0; all scoreboard entries invalid;
//   busy=0; counters=0. in_ready=0 while rst=1.
// - Scoreboard: shift register sb[0..HAZ_WIN-1] of {v, addr}. Every edge: sb[k] <= sb[k-1].
//   On accept: sb[0] <= {1, in_waddr}. Otherwise: sb[0] <= {0, 0}.
// - hazard (comb) = in_valid & OR_k sb[k].v & (sb[k].addr==in_raddr1 | sb[k].addr==in_raddr2).
// - Self reference (raddr == own waddr) is not a hazard. Duplicate sources are checked once.
// - in_ready (comb) = en & ~flush & ~hazard & ~rst. accept = in_valid & in_ready.
// - Issue register, 1-cycle latency: on accept, iss_* <= in_* and iss_valid <= 1.
//   Otherwise iss_valid <= 0 and iss_* hold their previous value.
// - Dependency timing: producer accepted at edge E0 -> dependent consumer is blocked at edges
//   E1..E(HAZ_WIN) and accepted at E(HAZ_WIN+1), i.e. exactly HAZ_WIN bubbles.
//   A consumer HAZ_WIN+1 or more instructions behind its producer issues back-to-back.
// - Source side holds in_* stable while in_valid & ~in_ready. Fields may change freely when in_valid=0.
// - en=0: no accept, bubbles issue, scoreboard keeps shifting (drains).
//   Stall counter does not count en=0 cycles.
// - flush=1 (priority over accept): iss_valid <= 0; all sb[k].v <= 0; counters unchanged.
// - stall_cnt increments on cycles with in_valid & en & ~flush & hazard.
//   issue_cnt increments on accept. Both saturate at 2^CNT_W-1 (no wrap).
// - busy = OR_k sb[k].v (comb). After the last accept, busy falls HAZ_WIN edges later.
// - Reset mid-stall: scoreboard cleared, so the pending consumer is accepted on the first edge
//   after rst deasserts (when en=1).
// TESTING
// - Reset: rst=1 mid-stream -> iss_valid=0, busy=0, counters=0, in_ready=0; after release,
//   first valid instr accepted next edge.
// - Independent stream: 6 instrs w1..w6, sources r20/r21 -> issued back-to-back,
//   issue_cnt=6, stall_cnt=0.
// - RAW: A(waddr=3) then B(raddr1=3), HAZ_WIN=3 -> exactly 3 bubbles between A and B; stall_cnt=3.
//   Repeat with HAZ_WIN=1 -> 1 bubble.
// - Distance: A(w=7), two independent instrs, then C(raddr2=7) -> C stalls 1 cycle.
//   Self ref D(w=9, r1=9) -> no stall.
// - Flush during stall: A(w=4), B(r1=4), flush at E1 -> B accepted at E2, busy=0 at E2.
//   en=0 for 5 cycles -> bubbles only, stall_cnt unchanged.
// - Saturation: CNT_W=4, 20 hazard-stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipeline_issue_ctrl_if.sv
// Fetch-to-issue bundle for the complex-ALU pipeline: instruction handshake in, issue registers out.
// The fetch side owns the master modport; the issue controller owns the slave modport.
interface pipeline_issue_ctrl_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_waddr;
  logic [AW-1:0] in_raddr1;
  logic [AW-1:0] in_raddr2;

  logic          iss_valid;
  logic [1:0]    iss_op;
  logic [AW-1:0] iss_waddr;
  logic [AW-1:0] iss_raddr1;
  logic [AW-1:0] iss_raddr2;

  modport master (
    output in_valid, in_op, in_waddr, in_raddr1, in_raddr2,
    input  in_ready, iss_valid, iss_op, iss_waddr, iss_raddr1, iss_raddr2
  );

  modport slave (
    input  in_valid, in_op, in_waddr, in_raddr1, in_raddr2,
    output in_ready, iss_valid, iss_op, iss_waddr, iss_raddr1, iss_raddr2
  );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// Issue scheduler for the 3-stage complex-ALU pipeline: RAW hazard detection against a
// shift-register scoreboard of in-flight destinations, bubble insertion and issue/stall statistics.
module pipeline_issue_ctrl #(
  parameter int HAZ_WIN = 3,
  parameter int AW      = 5,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  pipeline_issue_ctrl_if.slave io,
  output logic                 busy,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [HAZ_WIN-1:0] sb_v_q, sb_v_d;
  logic [AW-1:0]      sb_addr_q [HAZ_WIN];
  logic [AW-1:0]      sb_addr_d [HAZ_WIN];

  logic               iss_valid_q, iss_valid_d;
  logic [1:0]         iss_op_q, iss_op_d;
  logic [AW-1:0]      iss_waddr_q, iss_waddr_d;
  logic [AW-1:0]      iss_raddr1_q, iss_raddr1_d;
  logic [AW-1:0]      iss_raddr2_q, iss_raddr2_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               hazard_s;
  logic               accept_s;
  logic               stall_evt_s;

  // Only older instructions live in the scoreboard, so a self reference can never match.
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < HAZ_WIN; k++) begin
      hazard_s = hazard_s | (sb_v_q[k] & ((sb_addr_q[k] == io.in_raddr1) |
                                          (sb_addr_q[k] == io.in_raddr2)));
    end
    hazard_s    = hazard_s & io.in_valid;
    io.in_ready = en & ~flush & ~hazard_s & ~rst;
    accept_s    = io.in_valid & io.in_ready;
    stall_evt_s = io.in_valid & en & ~flush & hazard_s;
  end

  // Scoreboard shift; flush kills every in-flight entry (accept is already blocked by flush).
  always_comb begin
    sb_v_d       = {HAZ_WIN{1'b0}};
    sb_v_d[0]    = accept_s;
    sb_addr_d[0] = accept_s ? io.in_waddr : {AW{1'b0}};
    for (int k = 1; k < HAZ_WIN; k++) begin
      sb_v_d[k]    = sb_v_q[k-1] & ~flush;
      sb_addr_d[k] = sb_addr_q[k-1];
    end
  end

  // Issue register loads on accept, otherwise emits a bubble while holding the last fields.
  always_comb begin
    iss_valid_d  = accept_s;
    iss_op_d     = accept_s ? io.in_op     : iss_op_q;
    iss_waddr_d  = accept_s ? io.in_waddr  : iss_waddr_q;
    iss_raddr1_d = accept_s ? io.in_raddr1 : iss_raddr1_q;
    iss_raddr2_d = accept_s ? io.in_raddr2 : iss_raddr2_q;
    issue_cnt_d  = accept_s    ? sat_inc(issue_cnt_q) : issue_cnt_q;
    stall_cnt_d  = stall_evt_s ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v_q       <= {HAZ_WIN{1'b0}};
      for (int k = 0; k < HAZ_WIN; k++) begin
        sb_addr_q[k] <= {AW{1'b0}};
      end
      iss_valid_q  <= 1'b0;
      iss_op_q     <= 2'b00;
      iss_waddr_q  <= {AW{1'b0}};
      iss_raddr1_q <= {AW{1'b0}};
      iss_raddr2_q <= {AW{1'b0}};
      issue_cnt_q  <= {CNT_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      sb_v_q       <= sb_v_d;
      for (int k = 0; k < HAZ_WIN; k++) begin
        sb_addr_q[k] <= sb_addr_d[k];
      end
      iss_valid_q  <= iss_valid_d;
      iss_op_q     <= iss_op_d;
      iss_waddr_q  <= iss_waddr_d;
      iss_raddr1_q <= iss_raddr1_d;
      iss_raddr2_q <= iss_raddr2_d;
      issue_cnt_q  <= issue_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign io.iss_valid  = iss_valid_q;
  assign io.iss_op     = iss_op_q;
  assign io.iss_waddr  = iss_waddr_q;
  assign io.iss_raddr1 = iss_raddr1_q;
  assign io.iss_raddr2 = iss_raddr2_q;
  assign busy          = |sb_v_q;
  assign issue_cnt     = issue_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: three instances (HAZ_WIN=3, HAZ_WIN=1, CNT_W=4) share one stimulus
// stream and are checked against a per-instance model based on "cycle of last write per register".
module tb_pipeline_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_op = 2'd0;
  logic [4:0] in_waddr = 5'd0, in_raddr1 = 5'd0, in_raddr2 = 5'd0;

  always #5 clk = ~clk;

  pipeline_issue_ctrl_if #(.AW(5)) if0 ();
  pipeline_issue_ctrl_if #(.AW(5)) if1 ();
  pipeline_issue_ctrl_if #(.AW(5)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_op = in_op;        assign if1.in_op = in_op;        assign if2.in_op = in_op;
  assign if0.in_waddr = in_waddr;  assign if1.in_waddr = in_waddr;  assign if2.in_waddr = in_waddr;
  assign if0.in_raddr1 = in_raddr1; assign if1.in_raddr1 = in_raddr1; assign if2.in_raddr1 = in_raddr1;
  assign if0.in_raddr2 = in_raddr2; assign if1.in_raddr2 = in_raddr2; assign if2.in_raddr2 = in_raddr2;

  logic        busy0, busy1, busy2;
  logic [15:0] icnt0, scnt0, icnt1, scnt1;
  logic [3:0]  icnt2, scnt2;

  pipeline_issue_ctrl #(.HAZ_WIN(3), .AW(5), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .io(if0.slave),
    .busy(busy0), .issue_cnt(icnt0), .stall_cnt(scnt0));
  pipeline_issue_ctrl #(.HAZ_WIN(1), .AW(5), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .io(if1.slave),
    .busy(busy1), .issue_cnt(icnt1), .stall_cnt(scnt1));
  pipeline_issue_ctrl #(.HAZ_WIN(3), .AW(5), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .io(if2.slave),
    .busy(busy2), .issue_cnt(icnt2), .stall_cnt(scnt2));

  logic        o_rdy [3];
  logic        o_busy [3];
  logic [17:0] o_iss [3];
  logic [31:0] o_ic [3];
  logic [31:0] o_sc [3];

  always_comb begin
    o_rdy[0] = if0.in_ready; o_rdy[1] = if1.in_ready; o_rdy[2] = if2.in_ready;
    o_busy[0] = busy0;       o_busy[1] = busy1;       o_busy[2] = busy2;
    o_iss[0] = {if0.iss_valid, if0.iss_op, if0.iss_waddr, if0.iss_raddr1, if0.iss_raddr2};
    o_iss[1] = {if1.iss_valid, if1.iss_op, if1.iss_waddr, if1.iss_raddr1, if1.iss_raddr2};
    o_iss[2] = {if2.iss_valid, if2.iss_op, if2.iss_waddr, if2.iss_raddr1, if2.iss_raddr2};
    o_ic[0] = {16'd0, icnt0}; o_ic[1] = {16'd0, icnt1}; o_ic[2] = {28'd0, icnt2};
    o_sc[0] = {16'd0, scnt0}; o_sc[1] = {16'd0, scnt1}; o_sc[2] = {28'd0, scnt2};
  end

  int vectors = 0;
  int fails = 0;

  // Model: a register is busy while its latest accepted write is younger than HAZ_WIN edges
  // and newer than the latest flush/reset.
  int          hw [3]   = '{3, 1, 3};
  int          maxc [3] = '{65535, 65535, 15};
  int          last_wr [3][32];
  int          last_clr [3];
  int          edge_n = 0;
  bit          e_rdy [3];
  logic [17:0] e_iss [3];
  int          e_ic [3];
  int          e_sc [3];

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  function automatic bit live(input int m, input int a, input int n);
    return (last_wr[m][a] > last_clr[m]) && ((n - last_wr[m][a]) <= hw[m]);
  endfunction

  task automatic model_reset(input int m);
    e_iss[m]    = 18'd0;
    e_ic[m]     = 0;
    e_sc[m]     = 0;
    last_clr[m] = edge_n;
  endtask

  // One clock: check combinational outputs before the edge, update model at the edge, check after.
  task automatic step();
    bit haz [3];
    bit bsy;
    #1;
    for (int m = 0; m < 3; m++) begin
      if (rst) model_reset(m);
      haz[m]   = in_valid && (live(m, int'(in_raddr1), edge_n) || live(m, int'(in_raddr2), edge_n));
      e_rdy[m] = en && !flush && !haz[m] && !rst;
      bsy = 1'b0;
      for (int a = 0; a < 32; a++) if (live(m, a, edge_n)) bsy = 1'b1;
      chk("in_ready", m, 32'(o_rdy[m]), 32'(e_rdy[m]));
      chk("busy", m, 32'(o_busy[m]), 32'(bsy));
    end
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        model_reset(m);
      end else begin
        if (in_valid && en && !flush && haz[m] && e_sc[m] < maxc[m]) e_sc[m]++;
        if (flush) begin
          e_iss[m][17] = 1'b0;
          last_clr[m]  = edge_n;
        end else if (in_valid && e_rdy[m]) begin
          e_iss[m] = {1'b1, in_op, in_waddr, in_raddr1, in_raddr2};
          last_wr[m][in_waddr] = edge_n;
          if (e_ic[m] < maxc[m]) e_ic[m]++;
        end else begin
          e_iss[m][17] = 1'b0;
        end
      end
    end
    edge_n++;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("iss", m, 32'(o_iss[m]), 32'(e_iss[m]));
      chk("issue_cnt", m, o_ic[m], e_ic[m]);
      chk("stall_cnt", m, o_sc[m], e_sc[m]);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [4:0] w,
                       input logic [4:0] r1, input logic [4:0] r2);
    in_valid  = v;
    in_op     = op;
    in_waddr  = w;
    in_raddr1 = r1;
    in_raddr2 = r2;
    step();
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      for (int a = 0; a < 32; a++) last_wr[m][a] = -100;
      last_clr[m] = -1;
      e_rdy[m] = 1'b0; e_iss[m] = 18'd0; e_ic[m] = 0; e_sc[m] = 0;
    end
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    @(negedge clk);
    // Reset held with an instruction waiting, then an independent stream right after release
    repeat (2) drive(1'b1, 2'd1, 5'd1, 5'd20, 5'd21);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) drive(1'b1, 2'(i % 4), 5'(i), 5'd20, 5'd21);
    chk("stream_issue_cnt", 0, o_ic[0], 32'd6);
    chk("stream_stall_cnt", 0, o_sc[0], 32'd0);
    repeat (4) drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    // RAW: B depends on A
    drive(1'b1, 2'd2, 5'd3, 5'd20, 5'd21);
    repeat (4) drive(1'b1, 2'd3, 5'd10, 5'd3, 5'd21);
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    chk("raw_stall_hw3", 0, o_sc[0], 32'd3);
    chk("raw_stall_hw1", 1, o_sc[1], 32'd1);
    repeat (4) drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    // Distance 3 producer, then self reference
    drive(1'b1, 2'd0, 5'd7, 5'd20, 5'd21);
    drive(1'b1, 2'd0, 5'd11, 5'd20, 5'd21);
    drive(1'b1, 2'd0, 5'd12, 5'd20, 5'd21);
    repeat (2) drive(1'b1, 2'd1, 5'd13, 5'd20, 5'd7);
    drive(1'b1, 2'd2, 5'd9, 5'd9, 5'd20);
    chk("dist_stall_hw3", 0, o_sc[0], 32'd4);
    chk("dist_stall_hw1", 1, o_sc[1], 32'd1);
    chk("selfref_issued", 0, 32'(o_iss[0][17]), 32'd1);
    repeat (4) drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    // Flush during a stall
    drive(1'b1, 2'd0, 5'd4, 5'd20, 5'd21);
    flush = 1'b1;
    drive(1'b1, 2'd1, 5'd14, 5'd4, 5'd21);
    flush = 1'b0;
    chk("flush_busy", 0, 32'(o_busy[0]), 32'd0);
    drive(1'b1, 2'd1, 5'd14, 5'd4, 5'd21);
    chk("flush_then_issue", 0, 32'(o_iss[0][17]), 32'd1);
    // Issue disabled: bubbles only
    en = 1'b0;
    repeat (5) drive(1'b1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    en = 1'b1;
    chk("en0_stall_cnt", 0, o_sc[0], 32'd4);
    // 21 hazard-stall cycles: the CNT_W=4 instance must stick at 15
    repeat (7) begin
      drive(1'b1, 2'd0, 5'd5, 5'd20, 5'd21);
      repeat (4) drive(1'b1, 2'd1, 5'd6, 5'd5, 5'd20);
    end
    chk("sat_stall_w4", 2, o_sc[2], 32'd15);
    chk("sat_stall_w16", 0, o_sc[0], 32'd25);
    chk("sat_stall_hw1", 1, o_sc[1], 32'd8);
    repeat (4) drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    // Reset in the middle of a stall
    drive(1'b1, 2'd0, 5'd8, 5'd20, 5'd21);
    drive(1'b1, 2'd1, 5'd15, 5'd8, 5'd20);
    rst = 1'b1;
    drive(1'b1, 2'd1, 5'd15, 5'd8, 5'd20);
    rst = 1'b0;
    drive(1'b1, 2'd1, 5'd15, 5'd8, 5'd20);
    chk("rst_stall_issue", 0, 32'(o_iss[0]), 32'({1'b1, 2'd1, 5'd15, 5'd8, 5'd20}));
    chk("rst_stall_icnt", 0, o_ic[0], 32'd1);
    chk("rst_stall_scnt", 0, o_sc[0], 32'd0);
    // Random traffic on a small register range to provoke hazards
    repeat (400) begin
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      if (!(in_valid && !e_rdy[0])) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_op     = 2'($urandom_range(0, 3));
        in_waddr  = 5'($urandom_range(0, 7));
        in_raddr1 = 5'($urandom_range(0, 7));
        in_raddr2 = 5'($urandom_range(0, 7));
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
